// File: rtl/adder_nibble_seq.sv
// adder_nibble_seq: nibble-serial wide adder with valid/ready on both sides.
// Operands are captured on acceptance. One 4-bit slice add runs per clock,
// LSB nibble first, with the carry registered between nibbles. The wide sum
// and the final carry are then held until the consumer takes them.
// Optional feature: define ADDER_NIBBLE_SEQ_SUB_EN to add a 'sub' input.
// When sub=1 the block computes a - b; cout=1 then means no borrow.
module adder_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // ST_RESET keeps in_ready low while rst_n is asserted. IDLE is entered on
  // the first clock after reset is released.
  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     accept;
  logic                     last;

  logic [NIBBLES-1:0][3:0]  a_q;
  logic [NIBBLES-1:0][3:0]  b_q;
  logic [NIBBLES-1:0][3:0]  sum_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     carry_q;
  logic                     cout_q;
  logic                     carry_init;

  logic [3:0]               nib_b;
  logic [4:0]               nib_sum;

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  logic                     sub_q;
  assign carry_init = sub;
`else
  assign carry_init = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the values from before the clock edge.
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // The 4-bit add slice on the current nibble. Subtraction inverts b here.
  always_comb begin
    nib_b = b_q[idx_q];
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    nib_b = nib_b ^ {4{sub_q}};
`endif
    nib_sum = {1'b0, a_q[idx_q]} + {1'b0, nib_b} + {4'b0000, carry_q};
  end

  // Operand capture on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers have no reset. They are always loaded on
    // acceptance before they are read, so a reset would only add routing.
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Nibble sequencing: write the sum, propagate the carry, advance the index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= carry_init;
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
      sub_q   <= sub;
`endif
    end else if (state_q == ST_RUN) begin
      sum_q[idx_q] <= nib_sum[3:0];
      carry_q      <= nib_sum[4];
      idx_q        <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_q <= nib_sum[4];
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
